line_req_arbiter: RTL and testbench

LINE_REQ_ARBITER -- requirements
Module: line_req_arbiter

---
 rtl/line_arb_pkg.sv | 13 +
 rtl/line_req_slot.sv | 31 +++
 rtl/line_req_arbiter.sv | 155 +++++++++++++++
 tb/tb_line_req_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_arb_pkg.sv
// line_arb_pkg: shared widths, FSM encoding and request record for the line request arbiter
package line_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int MASK_W = 16;
  localparam int CNT_W  = 10;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WR_WAIT, S_RD_WAIT} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } line_req_t;
endpackage

// File: rtl/line_req_slot.sv
// line_req_slot: one pending request slot with held fields and an overflow pulse for dropped requests
module line_req_slot
  import line_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_i,
  input  logic      clr_i,
  input  line_req_t req_i,
  output logic      pend_o,
  output line_req_t req_o,
  output logic      ovf_o
);
  logic      pend_q, pend_d, take;
  line_req_t req_q;
  // a slot being issued this cycle is free to accept a new request
  assign take   = set_i && (!pend_q || clr_i);
  assign pend_d = take || (pend_q && !clr_i);
  assign ovf_o  = set_i && !take;
  assign pend_o = pend_q;
  assign req_o  = req_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (take) req_q <= req_i;
    end
  end
endmodule

// File: rtl/line_req_arbiter.sv
// line_req_arbiter: round-robin arbiter of uart/dcache line requests onto one downstream port
module line_req_arbiter
  import line_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_wstart_rq,
  input  logic              d_wstart_rq,
  input  logic [ADDR_W-1:0] u_waddr,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [LINE_W-1:0] u_wdata,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] u_wmask,
  input  logic [MASK_W-1:0] d_wmask,
  input  logic              u_rstart_rq,
  input  logic              d_rstart_rq,
  input  logic [ADDR_W-1:0] u_raddr,
  input  logic [ADDR_W-1:0] d_raddr,
  output logic              u_finish_wresp,
  output logic              d_finish_wresp,
  output logic              u_rdat_valid,
  output logic              d_rdat_valid,
  output logic              u_finish_mrd,
  output logic              d_finish_mrd,
  output logic [LINE_W-1:0] rdat_data,
  output logic              m_wstart_rq,
  output logic              m_rstart_rq,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [ADDR_W-1:0] m_raddr,
  output logic [LINE_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_wmask,
  input  logic              m_finish_wresp,
  input  logic              m_finish_mrd,
  input  logic              m_rdat_valid,
  input  logic [LINE_W-1:0] m_rdat_data,
  output logic              busy,
  output logic              grant_d,
  output logic              timeout_err,
  output logic              proto_err
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  state_t            state_q;
  logic              gnt_q, dir_q, ptr_q, terr_q, perr_q, m_wstart_q, m_rstart_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] m_waddr_q, m_raddr_q;
  logic [LINE_W-1:0] m_wdata_q;
  logic [MASK_W-1:0] m_wmask_q;
  logic [3:0]        set, clr, pend, ovf;
  line_req_t         req_in [4];
  line_req_t         req_held [4];
  line_req_t         win;
  logic              win_req, win_dir, wr_wait, rd_wait, to_hit, fin, wr_done, rd_done, rv;

  // slot index is {requester, direction}: 0 u-write, 1 u-read, 2 d-write, 3 d-read
  assign set       = {d_rstart_rq, d_wstart_rq, u_rstart_rq, u_wstart_rq};
  assign req_in[0] = '{addr: u_waddr, data: u_wdata, mask: u_wmask};
  assign req_in[1] = '{addr: u_raddr, data: '0, mask: '0};
  assign req_in[2] = '{addr: d_waddr, data: d_wdata, mask: d_wmask};
  assign req_in[3] = '{addr: d_raddr, data: '0, mask: '0};

  for (genvar i = 0; i < 4; i++) begin : g_slot
    line_req_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .set_i (set[i]),
      .clr_i (clr[i]),
      .req_i (req_in[i]),
      .pend_o(pend[i]),
      .req_o (req_held[i]),
      .ovf_o (ovf[i])
    );
  end

  assign win_req = ptr_q ? (pend[3] || pend[2]) : !(pend[1] || pend[0]);
  assign win_dir = !pend[{win_req, 1'b0}];
  assign win     = req_held[{win_req, win_dir}];
  assign clr     = (state_q == S_ISSUE) ? 4'(1) << {gnt_q, dir_q} : '0;

  assign wr_wait = state_q == S_WR_WAIT;
  assign rd_wait = state_q == S_RD_WAIT;
  assign to_hit  = (wr_wait || rd_wait) && cnt_q == TO_LAST;
  assign fin     = (wr_wait && m_finish_wresp) || (rd_wait && m_finish_mrd);
  assign wr_done = wr_wait && (m_finish_wresp || to_hit);
  assign rd_done = rd_wait && (m_finish_mrd || to_hit);
  assign rv      = rd_wait && m_rdat_valid;

  assign u_finish_wresp = wr_done && !gnt_q;
  assign d_finish_wresp = wr_done && gnt_q;
  assign u_rdat_valid   = rv && !gnt_q;
  assign d_rdat_valid   = rv && gnt_q;
  assign u_finish_mrd   = rd_done && !gnt_q;
  assign d_finish_mrd   = rd_done && gnt_q;
  assign rdat_data      = m_rdat_data;
  assign m_wstart_rq    = m_wstart_q;
  assign m_rstart_rq    = m_rstart_q;
  assign m_waddr        = m_waddr_q;
  assign m_raddr        = m_raddr_q;
  assign m_wdata        = m_wdata_q;
  assign m_wmask        = m_wmask_q;
  assign busy           = state_q != S_IDLE;
  assign grant_d        = gnt_q;
  assign timeout_err    = terr_q;
  assign proto_err      = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      dir_q      <= 1'b0;
      ptr_q      <= 1'b0;
      terr_q     <= 1'b0;
      perr_q     <= 1'b0;
      cnt_q      <= '0;
      m_wstart_q <= 1'b0;
      m_rstart_q <= 1'b0;
      m_waddr_q  <= '0;
      m_raddr_q  <= '0;
      m_wdata_q  <= '0;
      m_wmask_q  <= '0;
    end else begin
      m_wstart_q <= 1'b0;
      m_rstart_q <= 1'b0;
      if (|ovf) perr_q <= 1'b1;
      case (state_q)
        S_IDLE: if (|pend) begin
          state_q    <= S_ISSUE;
          gnt_q      <= win_req;
          dir_q      <= win_dir;
          m_wstart_q <= !win_dir;
          m_rstart_q <= win_dir;
          if (win_dir) m_raddr_q <= win.addr;
          else begin
            m_waddr_q <= win.addr;
            m_wdata_q <= win.data;
            m_wmask_q <= win.mask;
          end
        end
        S_ISSUE: begin
          state_q <= dir_q ? S_RD_WAIT : S_WR_WAIT;
          cnt_q   <= '0;
        end
        default: begin
          cnt_q <= cnt_q + 1'b1;
          if (wr_done || rd_done) begin
            state_q <= S_IDLE;
            ptr_q   <= !gnt_q;
            if (!fin) terr_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_req_arbiter.sv
// tb_line_req_arbiter: directed and randomized checks of line_req_arbiter against a slot-level model
module tb_line_req_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst;
  logic u_wstart_rq, d_wstart_rq, u_rstart_rq, d_rstart_rq;
  logic [31:0] u_waddr, d_waddr, u_raddr, d_raddr;
  logic [127:0] u_wdata, d_wdata;
  logic [15:0] u_wmask, d_wmask;
  logic u_finish_wresp, d_finish_wresp, u_rdat_valid, d_rdat_valid, u_finish_mrd, d_finish_mrd;
  logic [127:0] rdat_data;
  logic m_wstart_rq, m_rstart_rq;
  logic [31:0] m_waddr, m_raddr;
  logic [127:0] m_wdata;
  logic [15:0] m_wmask;
  logic m_finish_wresp, m_finish_mrd, m_rdat_valid;
  logic [127:0] m_rdat_data;
  logic busy, grant_d, timeout_err, proto_err;

  always #5 clk = ~clk;

  line_req_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .u_wstart_rq(u_wstart_rq), .d_wstart_rq(d_wstart_rq),
    .u_waddr(u_waddr), .d_waddr(d_waddr), .u_wdata(u_wdata), .d_wdata(d_wdata),
    .u_wmask(u_wmask), .d_wmask(d_wmask),
    .u_rstart_rq(u_rstart_rq), .d_rstart_rq(d_rstart_rq), .u_raddr(u_raddr), .d_raddr(d_raddr),
    .u_finish_wresp(u_finish_wresp), .d_finish_wresp(d_finish_wresp),
    .u_rdat_valid(u_rdat_valid), .d_rdat_valid(d_rdat_valid),
    .u_finish_mrd(u_finish_mrd), .d_finish_mrd(d_finish_mrd), .rdat_data(rdat_data),
    .m_wstart_rq(m_wstart_rq), .m_rstart_rq(m_rstart_rq), .m_waddr(m_waddr), .m_raddr(m_raddr),
    .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_finish_wresp(m_finish_wresp), .m_finish_mrd(m_finish_mrd),
    .m_rdat_valid(m_rdat_valid), .m_rdat_data(m_rdat_data),
    .busy(busy), .grant_d(grant_d), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  int checks = 0;
  int failures = 0;
  // model: slot s = 2*requester + direction (requester 0 = u, direction 1 = read)
  bit pend[4];
  logic [31:0] a_m[4];
  logic [127:0] w_m[4];
  logic [15:0] k_m[4];
  bit ptr_m, gnt_m, perr_m, terr_m;
  int order[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [5:0] resp(input bit r, input bit fw, input bit rv, input bit fm);
    return {fw && !r, fw && r, rv && !r, rv && r, fm && !r, fm && r};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) pend[s] = 0;
    ptr_m = 0; gnt_m = 0; perr_m = 0; terr_m = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    {u_wstart_rq, d_wstart_rq, u_rstart_rq, d_rstart_rq} = '0;
    {m_finish_wresp, m_finish_mrd, m_rdat_valid} = '0;
    m_rdat_data = rnd128();
    chk("proto_err", proto_err, perr_m);
    chk("timeout_err", timeout_err, terr_m);
    chk("grant_d", grant_d, gnt_m);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e);
    #1;
    chk({tag, "/resp"}, {u_finish_wresp, d_finish_wresp, u_rdat_valid, d_rdat_valid, u_finish_mrd, d_finish_mrd}, e);
    chk({tag, "/rdat"}, rdat_data, m_rdat_data);
  endtask

  task automatic stray();
    m_finish_wresp = 1'($urandom_range(0, 1));
    m_finish_mrd   = 1'($urandom_range(0, 1));
    m_rdat_valid   = 1'($urandom_range(0, 1));
  endtask

  task automatic send_one(input int s, input logic [31:0] a);
    logic [127:0] w;
    logic [15:0] m;
    w = rnd128();
    m = 16'($urandom);
    case (s)
      0: begin u_wstart_rq = 1; u_waddr = a; u_wdata = w; u_wmask = m; end
      1: begin u_rstart_rq = 1; u_raddr = a; end
      2: begin d_wstart_rq = 1; d_waddr = a; d_wdata = w; d_wmask = m; end
      default: begin d_rstart_rq = 1; d_raddr = a; end
    endcase
    if (pend[s]) perr_m = 1;
    else begin pend[s] = 1; a_m[s] = a; w_m[s] = w; k_m[s] = m; end
  endtask

  // called in the IDLE cycle before the expected ISSUE cycle
  task automatic txn(input int fin_k, input bit wrong, input bit extra);
    bit r, dr;
    int s, c;
    if (pend[2 * int'(ptr_m)] || pend[2 * int'(ptr_m) + 1]) r = ptr_m;
    else r = !ptr_m;
    dr = !pend[2 * int'(r)];
    s = 2 * int'(r) + int'(dr);
    gnt_m = r;
    step();
    order.push_back(2 * int'(grant_d) + int'(m_rstart_rq));
    stray();
    chk_out("issue", '0);
    chk("busy_issue", busy, 1'b1);
    chk("m_wstart", m_wstart_rq, !dr);
    chk("m_rstart", m_rstart_rq, dr);
    if (dr) chk("m_raddr", m_raddr, a_m[s]);
    else begin
      chk("m_waddr", m_waddr, a_m[s]);
      chk("m_wdata", m_wdata, w_m[s]);
      chk("m_wmask", m_wmask, k_m[s]);
    end
    pend[s] = 0;
    c = fin_k < TO ? fin_k : TO;
    for (int k = 1; k <= c; k++) begin
      bit rv;
      step();
      chk("busy_wait", busy, 1'b1);
      chk("m_start_wait", {m_wstart_rq, m_rstart_rq}, 2'b00);
      rv = 1'($urandom_range(0, 1));
      m_rdat_valid = rv;
      if (k == fin_k) begin if (dr) m_finish_mrd = 1; else m_finish_wresp = 1; end
      if (wrong && $urandom_range(0, 2) == 0) begin if (dr) m_finish_wresp = 1; else m_finish_mrd = 1; end
      if (extra && k < c && $urandom_range(0, 3) == 0) send_one(int'($urandom_range(0, 3)), $urandom);
      chk_out("wait", resp(r, !dr && k == c, dr && rv, dr && k == c));
    end
    if (fin_k > TO) terr_m = 1;
    ptr_m = !r;
  endtask

  task automatic drain(input int fin_k, input bit wrong, input bit extra);
    while (pend[0] || pend[1] || pend[2] || pend[3]) begin
      step();
      stray();
      chk_out("idle", '0);
      chk("busy_idle", busy, 1'b0);
      chk("m_start_idle", {m_wstart_rq, m_rstart_rq}, 2'b00);
      txn(fin_k != 0 ? fin_k : ($urandom_range(0, 7) == 0 ? 99 : int'($urandom_range(1, TO))), wrong, extra);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/resp"}, {u_finish_wresp, d_finish_wresp, u_rdat_valid, d_rdat_valid, u_finish_mrd, d_finish_mrd}, 6'd0);
    chk({tag, "/rdat"}, rdat_data, '0);
    chk({tag, "/m_start"}, {m_wstart_rq, m_rstart_rq}, 2'b00);
    chk({tag, "/m_addr"}, {m_waddr, m_raddr}, 64'd0);
    chk({tag, "/m_wdata"}, m_wdata, '0);
    chk({tag, "/m_wmask"}, m_wmask, 16'd0);
    chk({tag, "/status"}, {busy, grant_d, timeout_err, proto_err}, 4'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    {u_wstart_rq, d_wstart_rq, u_rstart_rq, d_rstart_rq} = '0;
    {u_waddr, d_waddr, u_raddr, d_raddr} = '0;
    {u_wdata, d_wdata, u_wmask, d_wmask} = '0;
    {m_finish_wresp, m_finish_mrd, m_rdat_valid} = '0;
    m_rdat_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;

    order.delete(); step(); send_one(0, 32'h100); send_one(2, 32'h200); drain(3, 0, 0);
    chk("rr_pair1_first", order[0], 0);
    chk("rr_pair1_second", order[1], 2);

    order.delete(); step(); send_one(1, 32'h1000); drain(1, 0, 0);
    chk("rd_alone_slot", order[0], 1);
    step(); #1; chk("busy_after_rd", busy, 1'b0);

    order.delete(); step(); send_one(0, 32'h300); send_one(2, 32'h400); drain(2, 0, 0);
    chk("rr_pair2_first", order[0], 2);
    chk("rr_pair2_second", order[1], 0);

    order.delete(); step(); send_one(2, 32'h2000); send_one(3, 32'h2000); drain(4, 0, 0);
    chk("wr_before_rd_first", order[0], 2);
    chk("wr_before_rd_second", order[1], 3);

    step(); send_one(0, 32'h3000); drain(99, 0, 0);
    step(); m_finish_wresp = 1; chk_out("late_finish", '0);
    chk("timeout_err_set", timeout_err, 1'b1);
    chk("busy_after_timeout", busy, 1'b0);

    step(); send_one(0, 32'h4000);
    step(); send_one(0, 32'h5000);
    txn(3, 0, 0);
    step(); chk("proto_err_set", proto_err, 1'b1);

    repeat (60) begin
      int sel;
      step();
      sel = int'($urandom_range(1, 15));
      for (int s = 0; s < 4; s++) if (sel[s]) send_one(s, $urandom);
      drain(0, 1, 1);
    end

    step(); send_one(1, 32'h6000);
    step();
    gnt_m = 0; pend[1] = 0;
    step(); chk("m_rstart_pre_rst", m_rstart_rq, 1'b1);
    step(); chk("busy_rd_wait", busy, 1'b1);
    rst = 1;
    m_rdat_data = '0;
    @(posedge clk); #1;
    model_reset();
    chk_zero("mid_reset");
    rst = 0;
    step(); m_finish_mrd = 1; chk_out("post_rst_finish", '0);
    chk("busy_post_rst", busy, 1'b0);
    step(); chk_out("post_rst_idle", '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
